// File: rtl/billiard_fx_pkg.sv
// Shared fixed-point constants and FSM state encoding for the billiard physics datapath.
package billiard_fx_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned FRAC_WIDTH = 30;

  localparam logic [WIDTH-1:0] FX_ONE = {{(WIDTH-FRAC_WIDTH-1){1'b0}}, 1'b1, {FRAC_WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0] FX_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] FX_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    MUL_X,
    MUL_Y,
    UPD_X,
    UPD_Y,
    DONE
  } state_t;

endpackage

// File: rtl/fx_mul_sat.sv
// Combinational signed fixed-point multiply, floor-truncated, saturating to the word range.
module fx_mul_sat #(
  parameter int unsigned WIDTH      = billiard_fx_pkg::WIDTH,
  parameter int unsigned FRAC_WIDTH = billiard_fx_pkg::FRAC_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             sat
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned TOP  = FRAC_WIDTH + WIDTH - 1;
  localparam int unsigned HI_W = PW - TOP;
  localparam logic [WIDTH-1:0] POS_LIM = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_LIM = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [PW-1:0] ea;
  logic signed [PW-1:0] eb;
  logic signed [PW-1:0] prod;
  logic [HI_W-1:0]      hi;
  logic                 unused_lsb;

  // Full-width product; overflow when the bits above the result's sign bit disagree.
  always_comb begin
    ea   = {{WIDTH{a[WIDTH-1]}}, a};
    eb   = {{WIDTH{b[WIDTH-1]}}, b};
    prod = ea * eb;
    hi   = prod[PW-1:TOP];
    sat  = ~((&hi) | ~(|hi));
    if (sat) begin
      y = prod[PW-1] ? NEG_LIM : POS_LIM;
    end else begin
      y = prod[TOP:FRAC_WIDTH];
    end
  end

  assign unused_lsb = ^prod[FRAC_WIDTH-1:0];

endmodule

// File: rtl/velocity_reflector.sv
// Reflects an approaching velocity about a unit contact normal using one shared multiplier.
module velocity_reflector #(
  parameter int unsigned WIDTH      = billiard_fx_pkg::WIDTH,
  parameter int unsigned FRAC_WIDTH = billiard_fx_pkg::FRAC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] vx,
  input  logic [WIDTH-1:0] vy,
  input  logic [WIDTH-1:0] nx,
  input  logic [WIDTH-1:0] ny,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] vx_out,
  output logic [WIDTH-1:0] vy_out,
  output logic             out_reflected,
  output logic             out_sat
);

  import billiard_fx_pkg::*;

  localparam logic [WIDTH-1:0] POS_LIM = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_LIM = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_n;
  logic [WIDTH-1:0] vx_r, vy_r, nx_r, ny_r;
  logic [WIDTH-1:0] vx_n, vy_n, nx_n, ny_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] k, k_n;
  logic             sat, sat_n;
  logic [WIDTH-1:0] vx_out_n, vy_out_n;
  logic             refl_n, out_sat_n, out_valid_n, in_ready_n;

  logic [WIDTH-1:0] mul_a, mul_b, mul_y;
  logic             mul_sat;
  logic [WIDTH:0]   add_res;
  logic [WIDTH:0]   dbl_res;

  // Saturating add/sub; MSB of the result flags a clamp.
  function automatic logic [WIDTH:0] add_sat(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             sub);
    logic [WIDTH:0] s;
    if (sub) s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    else     s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1]) add_sat = {1'b1, (s[WIDTH] ? NEG_LIM : POS_LIM)};
    else                        add_sat = {1'b0, s[WIDTH-1:0]};
  endfunction

  fx_mul_sat #(
    .WIDTH      (WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_mul (
    .a   (mul_a),
    .b   (mul_b),
    .y   (mul_y),
    .sat (mul_sat)
  );

  // Multiplier operand selection by datapath step.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MUL_X: begin mul_a = vx_r; mul_b = nx_r; end
      MUL_Y: begin mul_a = vy_r; mul_b = ny_r; end
      UPD_X: begin mul_a = k;    mul_b = nx_r; end
      UPD_Y: begin mul_a = k;    mul_b = ny_r; end
      default: ;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_n  = state;
    vx_n     = vx_r;
    vy_n     = vy_r;
    nx_n     = nx_r;
    ny_n     = ny_r;
    acc_n    = acc;
    k_n      = k;
    sat_n    = sat;
    vx_out_n = vx_out;
    vy_out_n = vy_out;
    refl_n   = out_reflected;
    add_res  = '0;
    dbl_res  = '0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          vx_n    = vx;
          vy_n    = vy;
          nx_n    = nx;
          ny_n    = ny;
          acc_n   = '0;
          sat_n   = 1'b0;
          state_n = MUL_X;
        end
      end
      MUL_X: begin
        acc_n   = mul_y;
        sat_n   = sat | mul_sat;
        state_n = MUL_Y;
      end
      MUL_Y: begin
        add_res = add_sat(acc, mul_y, 1'b0);
        sat_n   = sat | mul_sat | add_res[WIDTH];
        if (!add_res[WIDTH-1]) begin
          vx_out_n = vx_r;
          vy_out_n = vy_r;
          refl_n   = 1'b0;
          state_n  = DONE;
        end else begin
          dbl_res = add_sat(add_res[WIDTH-1:0], add_res[WIDTH-1:0], 1'b0);
          k_n     = dbl_res[WIDTH-1:0];
          sat_n   = sat | mul_sat | add_res[WIDTH] | dbl_res[WIDTH];
          state_n = UPD_X;
        end
      end
      UPD_X: begin
        add_res  = add_sat(vx_r, mul_y, 1'b1);
        vx_out_n = add_res[WIDTH-1:0];
        sat_n    = sat | mul_sat | add_res[WIDTH];
        state_n  = UPD_Y;
      end
      UPD_Y: begin
        add_res  = add_sat(vy_r, mul_y, 1'b1);
        vy_out_n = add_res[WIDTH-1:0];
        sat_n    = sat | mul_sat | add_res[WIDTH];
        refl_n   = 1'b1;
        state_n  = DONE;
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    out_valid_n = (state_n == DONE);
    in_ready_n  = (state_n == IDLE);
    out_sat_n   = (state_n == DONE) ? sat_n : out_sat;
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      vx_r          <= '0;
      vy_r          <= '0;
      nx_r          <= '0;
      ny_r          <= '0;
      acc           <= '0;
      k             <= '0;
      sat           <= 1'b0;
      vx_out        <= '0;
      vy_out        <= '0;
      out_reflected <= 1'b0;
      out_sat       <= 1'b0;
      out_valid     <= 1'b0;
      in_ready      <= 1'b0;
    end else begin
      state         <= state_n;
      vx_r          <= vx_n;
      vy_r          <= vy_n;
      nx_r          <= nx_n;
      ny_r          <= ny_n;
      acc           <= acc_n;
      k             <= k_n;
      sat           <= sat_n;
      vx_out        <= vx_out_n;
      vy_out        <= vy_out_n;
      out_reflected <= refl_n;
      out_sat       <= out_sat_n;
      out_valid     <= out_valid_n;
      in_ready      <= in_ready_n;
    end
  end

endmodule

// File: tb/tb_velocity_reflector.sv
// Self-checking bench for velocity_reflector against an arithmetic reference model.
module tb_velocity_reflector;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] vx, vy, nx, ny;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] vx_out, vy_out;
  logic        out_reflected;
  logic        out_sat;

  int total;
  int bad;
  int cyc;
  bit m_sat;

  velocity_reflector dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .vx            (vx),
    .vy            (vy),
    .nx            (nx),
    .ny            (ny),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .vx_out        (vx_out),
    .vy_out        (vy_out),
    .out_reflected (out_reflected),
    .out_sat       (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic on plain 64-bit integers.
  function automatic longint sx(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint clip(input longint raw);
    longint c;
    c = raw;
    if (raw > 64'sd2147483647)  c = 64'sd2147483647;
    if (raw < -64'sd2147483648) c = -64'sd2147483648;
    if (c != raw) m_sat = 1'b1;
    return c;
  endfunction

  function automatic longint fmul(input longint a, input longint b);
    return clip((a * b) >>> 30);
  endfunction

  task automatic ref_model(input logic [31:0] ivx, ivy, inx, iny,
                           output logic [31:0] ex, ey, output logic er, es);
    longint d, k;
    m_sat = 1'b0;
    d = clip(fmul(sx(ivx), sx(inx)) + fmul(sx(ivy), sx(iny)));
    if (d >= 0) begin
      ex = ivx; ey = ivy; er = 1'b0;
    end else begin
      k  = clip(d + d);
      ex = 32'(clip(sx(ivx) - fmul(k, sx(inx))));
      ey = 32'(clip(sx(ivy) - fmul(k, sx(iny))));
      er = 1'b1;
    end
    es = m_sat;
  endtask

  // Presents one input (called at a negedge), waits for out_valid; returns at a negedge.
  task automatic launch(input logic [31:0] ivx, ivy, inx, iny,
                        output int lat, output logic acc_ok, output int acc_cyc);
    acc_ok   = in_ready;
    vx = ivx; vy = ivy; nx = inx; ny = iny;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0;
    vx = $urandom; vy = $urandom; nx = $urandom; ny = $urandom;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // Holds backpressure for a while, then completes the result handshake.
  task automatic handshake(input int hold, output logic post_ok);
    out_ready = 1'b0;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    post_ok = in_ready && !out_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    vx = '0; vy = '0; nx = '0; ny = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, out_valid, vx_out, vy_out, out_reflected, out_sat} !== 68'd0) begin
      bad++;
      $display("FAIL reset_values: got rdy=%b vld=%b vx=%h vy=%h r=%b s=%b want all zero",
               in_ready, out_valid, vx_out, vy_out, out_reflected, out_sat);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  // Directed transaction compared against constant expectations.
  task automatic directed(input string name, input logic [31:0] ivx, ivy, inx, iny,
                          input logic [31:0] ex, ey, input logic er, es, input int elat);
    int lat, ac; logic aok, pok;
    launch(ivx, ivy, inx, iny, lat, aok, ac);
    total++;
    if (lat !== elat || aok !== 1'b1) begin
      bad++;
      $display("FAIL %s_latency: got %0d (ready=%b) want %0d", name, lat, aok, elat);
    end
    total++;
    if ({vx_out, vy_out} !== {ex, ey}) begin
      bad++;
      $display("FAIL %s_value: got %h,%h want %h,%h", name, vx_out, vy_out, ex, ey);
    end
    total++;
    if ({out_reflected, out_sat} !== {er, es}) begin
      bad++;
      $display("FAIL %s_flags: got refl=%b sat=%b want refl=%b sat=%b",
               name, out_reflected, out_sat, er, es);
    end
    handshake(0, pok);
    total++;
    if (pok !== 1'b1) begin
      bad++;
      $display("FAIL %s_handshake: got in_ready=%b out_valid=%b want 1,0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reflect_head_on;
    directed("head_on", 32'h2000_0000, 32'h0, 32'hC000_0000, 32'h0,
             32'hE000_0000, 32'h0, 1'b1, 1'b0, 4);
  endtask

  task automatic test_pass_through;
    directed("pass", 32'h2000_0000, 32'h0, 32'h4000_0000, 32'h0,
             32'h2000_0000, 32'h0, 1'b0, 1'b0, 2);
    directed("grazing", 32'h0, 32'h1234_5678, 32'h4000_0000, 32'h0,
             32'h0, 32'h1234_5678, 1'b0, 1'b0, 2);
  endtask

  task automatic test_saturation;
    directed("sat", 32'h6000_0000, 32'h0, 32'hC000_0000, 32'h0,
             32'hE000_0001, 32'h0, 1'b1, 1'b1, 4);
  endtask

  task automatic test_diagonal;
    directed("diag", 32'h2000_0000, 32'hE000_0000, 32'h0, 32'h4000_0000,
             32'h2000_0000, 32'h2000_0000, 1'b1, 1'b0, 4);
  endtask

  task automatic test_backpressure;
    int lat, ac, ac2; logic aok, pok;
    logic [31:0] hx, hy; logic hr, hs;
    int unstable;
    launch(32'h2000_0000, 32'h0, 32'hC000_0000, 32'h0, lat, aok, ac);
    hx = vx_out; hy = vy_out; hr = out_reflected; hs = out_sat;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      vx = 32'h1000_0000; vy = 32'h0; nx = 32'h4000_0000; ny = 32'h0;
      @(negedge clk);
      if (!out_valid || in_ready || {vx_out, vy_out, out_reflected, out_sat} !== {hx, hy, hr, hs})
        unstable++;
    end
    in_valid = 1'b0;
    total++;
    if (unstable !== 0 || {hx, hr} !== {32'hE000_0000, 1'b1}) begin
      bad++;
      $display("FAIL backpressure_hold: got %0d unstable cycles, vx=%h want 0, E0000000", unstable, hx);
    end
    handshake(0, pok);
    total++;
    if (pok !== 1'b1) begin
      bad++;
      $display("FAIL backpressure_release: got in_ready=%b out_valid=%b want 1,0", in_ready, out_valid);
    end
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL backpressure_no_extra: got vld=%b rdy=%b want 0,1", out_valid, in_ready);
    end
    ac2 = ac;
  endtask

  task automatic test_reset_mid;
    int seen;
    vx = 32'h2000_0000; vy = '0; nx = 32'hC000_0000; ny = '0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || vx_out !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_abort: got vld=%b rdy=%b vx=%h want 0,0,0", out_valid, in_ready, vx_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_release: got rdy=%b want 1", in_ready);
    end
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL reset_mid_partial: got %0d valid cycles want 0", seen);
    end
    directed("after_reset", 32'h2000_0000, 32'h0, 32'hC000_0000, 32'h0,
             32'hE000_0000, 32'h0, 1'b1, 1'b0, 4);
  endtask

  task automatic test_back_to_back;
    int lat, ac1, ac2; logic aok, pok;
    launch(32'h2000_0000, 32'h0, 32'hC000_0000, 32'h0, lat, aok, ac1);
    handshake(0, pok);
    launch(32'h0, 32'h1000_0000, 32'h0, 32'hC000_0000, lat, aok, ac2);
    total++;
    if (ac2 - ac1 !== 6 || aok !== 1'b1) begin
      bad++;
      $display("FAIL back_to_back_period: got %0d (ready=%b) want 6", ac2 - ac1, aok);
    end
    total++;
    if ({vx_out, vy_out, out_reflected} !== {32'h0, 32'hF000_0000, 1'b1}) begin
      bad++;
      $display("FAIL back_to_back_value: got %h,%h r=%b want 0,F0000000 r=1", vx_out, vy_out, out_reflected);
    end
    handshake(0, pok);
  endtask

  task automatic test_random;
    logic [31:0] a, b, c, d, ex, ey;
    logic er, es, aok, pok;
    int lat, ac, mode;
    for (int t = 0; t < 60; t++) begin
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        a = $urandom; b = $urandom; c = $urandom; d = $urandom;
      end else begin
        a = 32'($urandom_range(0, 32'h8000_0000)) - 32'h4000_0000;
        b = 32'($urandom_range(0, 32'h8000_0000)) - 32'h4000_0000;
        c = 32'($urandom_range(0, 32'h8000_0000)) - 32'h4000_0000;
        d = 32'($urandom_range(0, 32'h8000_0000)) - 32'h4000_0000;
        if (mode == 2) begin
          c = $urandom_range(0, 1) ? 32'h4000_0000 : 32'hC000_0000;
          d = 32'h0;
        end
      end
      ref_model(a, b, c, d, ex, ey, er, es);
      launch(a, b, c, d, lat, aok, ac);
      total++;
      if (lat !== (er ? 4 : 2) || {vx_out, vy_out, out_reflected, out_sat} !== {ex, ey, er, es}) begin
        bad++;
        $display("FAIL random_%0d: in %h %h %h %h got lat=%0d %h %h r=%b s=%b want lat=%0d %h %h r=%b s=%b",
                 t, a, b, c, d, lat, vx_out, vy_out, out_reflected, out_sat,
                 er ? 4 : 2, ex, ey, er, es);
      end
      handshake($urandom_range(0, 3), pok);
      total++;
      if (pok !== 1'b1) begin
        bad++;
        $display("FAIL random_handshake_%0d: got rdy=%b vld=%b want 1,0", t, in_ready, out_valid);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    test_reset();
    test_reflect_head_on();
    test_pass_through();
    test_saturation();
    test_diagonal();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
